// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single req/gnt + rvalid memory port.
// D has priority; a saturating starvation counter forces an I grant after STARVE_LIMIT D wins.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ready,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ready,
  output logic                    m_req,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_be,
  input  logic                    m_gnt,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    busy
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  own_d_q, own_d_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  m_req_q, m_req_d;
  logic                  m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]       m_be_q, m_be_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                  i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic                  busy_q, busy_d;
  logic                  pick_i;

  // Memory is word addressed; the byte offset is carried by the byte enables.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{i_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    own_d_d      = own_d_q;
    starve_cnt_d = starve_cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_be_d       = m_be_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    pick_i       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          pick_i  = i_req && (!d_req || starve_cnt_q == LIMIT);
          own_d_d = !pick_i;
          // Only D wins taken against a waiting I count toward starvation.
          if (!pick_i && i_req)
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
          else
            starve_cnt_d = '0;
          m_req_d   = 1'b1;
          m_we_d    = pick_i ? 1'b0 : d_we;
          m_addr_d  = pick_i ? {i_addr[ADDR_WIDTH-1:2], 2'b00} : {d_addr[ADDR_WIDTH-1:2], 2'b00};
          m_wdata_d = pick_i ? '0 : d_wdata;
          m_be_d    = pick_i ? '1 : d_be;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (m_gnt) begin
          m_req_d = 1'b0;
          if (m_we_q) begin
            // Posted write: completes on the grant.
            i_ready_d = !own_d_q;
            d_ready_d = own_d_q;
            state_d   = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          if (own_d_q) begin
            d_rdata_d = m_rdata;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = m_rdata;
            i_ready_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      own_d_q      <= 1'b0;
      starve_cnt_q <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_be_q       <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      own_d_q      <= own_d_d;
      starve_cnt_q <= starve_cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_be_q       <= m_be_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_be    = m_be_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign busy    = busy_q;
endmodule
